// File: rtl/mux_pkg.sv
// Shared definitions for the N:1 streaming multiplexer.
// Mode encodings and flat-bus word extraction helper.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  localparam int unsigned BUS_MAX  = 4096;
  localparam int unsigned WORD_MAX = 256;

  function automatic logic [WORD_MAX-1:0] ch_word(
    input logic [BUS_MAX-1:0] bus,
    input int unsigned        c,
    input int unsigned        w
  );
    return WORD_MAX'(bus >> (c * w));
  endfunction

endpackage

// File: rtl/mux_stream_nto1_rr_arbiter.sv
// Round-robin arbiter: first request strictly after ptr, wrapping.
// Built only when MUX_RR_EN is defined.
module rr_arbiter #(
  parameter int NUM_CH = 16,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [NUM_CH-1:0] gnt_oh,
  output logic [SEL_W-1:0]  gnt_idx,
  output logic              gnt_ok
);

  always_comb begin
    int c;
    gnt_idx = '0;
    gnt_ok  = |req;
    // Scan farthest-first so the nearest requester wins last.
    for (int i = NUM_CH; i >= 1; i--) begin
      c = (int'(ptr) + i) % NUM_CH;
      if (req[c]) gnt_idx = SEL_W'(c);
    end
    gnt_oh = gnt_ok ? (NUM_CH'(1) << gnt_idx) : '0;
  end

endmodule

// File: rtl/mux_stream_nto1.sv
// N:1 valid/ready stream mux with registered output.
// Round-robin mode and its pointer exist only with MUX_RR_EN.
module mux_stream_nto1
  import mux_pkg::*;
#(
  parameter int NUM_CH = 16,
  parameter int DATA_W = 16,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0]        in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_ch,
  input  logic                     out_ready
);

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0]  out_ch_q, out_ch_d;

  logic              space;
  logic              fix_ok;
  logic              rr_sel;
  logic [SEL_W-1:0]  grant;
  logic              grant_ok;
  logic              xfer;
  logic [DATA_W-1:0] grant_word;

  assign space  = !out_valid_q | out_ready;
  assign fix_ok = int'(sel) < NUM_CH;

`ifdef MUX_RR_EN
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [NUM_CH-1:0] rr_oh;
  logic [SEL_W-1:0]  rr_idx;
  logic              rr_ok;
  logic              unused_rr;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .SEL_W  (SEL_W)
  ) u_arb (
    .req     (in_valid),
    .ptr     (ptr_q),
    .gnt_oh  (rr_oh),
    .gnt_idx (rr_idx),
    .gnt_ok  (rr_ok)
  );

  assign unused_rr = |rr_oh;
  assign rr_sel    = (mode == MODE_RR);
  assign grant     = rr_sel ? rr_idx : sel;
  assign grant_ok  = rr_sel ? rr_ok : fix_ok;
`else
  logic unused_mode;

  assign unused_mode = mode;
  assign rr_sel      = MODE_FIXED;
  assign grant       = sel;
  assign grant_ok    = fix_ok;
`endif

  assign grant_word = DATA_W'(ch_word(BUS_MAX'(in_data),
                                      int'(grant), DATA_W));

  always_comb begin
    in_ready = '0;
    if (en && space && grant_ok) in_ready[grant] = 1'b1;
  end

  assign xfer = in_valid[grant] & in_ready[grant];

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = grant_word;
      out_ch_d    = grant;
    end else if (!en || (out_valid_q && out_ready)) begin
      out_valid_d = 1'b0;
      out_data_d  = '0;
      out_ch_d    = '0;
    end
  end

`ifdef MUX_RR_EN
  always_comb begin
    ptr_d = ptr_q;
    if (xfer && rr_sel) ptr_d = grant;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= SEL_W'(NUM_CH - 1);
    else     ptr_q <= ptr_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_mux_stream_nto1.sv
// Self-checking bench for mux_stream_nto1 against a behavioural model.
// Round-robin checks are compiled in only with MUX_RR_EN.
module tb_mux_stream_nto1;

  localparam int N  = 16;
  localparam int W  = 16;
  localparam int SW = 4;

`ifdef MUX_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           en;
  logic           mode;
  logic [SW-1:0]  sel;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_ch;
  logic           out_ready;

  mux_stream_nto1 #(.NUM_CH(N), .DATA_W(W), .SEL_W(SW)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  bit       m_valid;
  logic [W-1:0] m_data;
  int       m_ch;
  int       m_ptr;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Granted channel from the rules, or -1 when nothing may be granted.
  function automatic int m_grant();
    if (!(RR && mode)) return (int'(sel) < N) ? int'(sel) : -1;
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (m_ptr + k) % N;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  task automatic cycle();
    int         g;
    bit         xfer;
    logic [N-1:0] exp_rdy;
    #1;
    g = m_grant();
    exp_rdy = '0;
    if (en && (!m_valid || out_ready) && g >= 0) exp_rdy[g] = 1'b1;
    if (!rst) chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    xfer = (g >= 0) && exp_rdy[g] && in_valid[g];
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_data = '0; m_ch = 0; m_ptr = N - 1;
    end else if (xfer) begin
      m_valid = 1;
      m_data  = in_data[g*W +: W];
      m_ch    = g;
      if (RR && mode) m_ptr = g;
    end else if (!en || (m_valid && out_ready)) begin
      m_valid = 0; m_data = '0; m_ch = 0;
    end
    @(negedge clk);
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    chk("out_data", 64'(out_data), 64'(m_data));
    chk("out_ch", 64'(out_ch), 64'(m_ch));
  endtask

  task automatic set_word(input int c, input logic [W-1:0] v);
    in_data[c*W +: W] = v;
  endtask

  initial begin
    logic [W-1:0] held_d;
    logic [SW-1:0] held_c;
    int exp_seq[5];

    rst = 1; en = 0; mode = 0; sel = '0; out_ready = 0;
    in_valid = '0; in_data = '0;
    m_valid = 0; m_data = '0; m_ch = 0; m_ptr = N - 1;
    cycle();
    cycle();
    chk("reset_valid", 64'(out_valid), 64'd0);
    chk("reset_data", 64'(out_data), 64'd0);
    rst = 0;

    // Fixed-select sweep.
    en = 1; out_ready = 1; in_valid = '1;
    for (int c = 0; c < N; c++) set_word(c, W'(16'hA000 + c));
    for (int s = 0; s < N; s++) begin
      sel = SW'(s);
      cycle();
      chk("sweep_data", 64'(out_data), 64'(16'hA000 + s));
      chk("sweep_ch", 64'(out_ch), 64'(s));
    end

    // Enable low flushes a held word.
    sel = 4'd0; set_word(0, 16'h1234);
    cycle();
    chk("en_load", 64'(out_data), 64'h1234);
    en = 0;
    cycle();
    chk("en_off_valid", 64'(out_valid), 64'd0);
    chk("en_off_data", 64'(out_data), 64'd0);
    cycle();
    chk("en_off_rdy", 64'(in_ready), 64'd0);
    en = 1;

    // Selected channel idle: nothing moves until it raises valid.
    sel = 4'd3; in_valid = '1; in_valid[3] = 1'b0; set_word(3, 16'h0333);
    repeat (3) cycle();
    chk("idle_sel_valid", 64'(out_valid), 64'd0);
    in_valid[3] = 1'b1;
    cycle();
    chk("idle_sel_word", 64'(out_data), 64'h0333);

    // Backpressure then drain-and-refill on one edge.
    out_ready = 0;
    held_d = out_data; held_c = out_ch;
    set_word(3, 16'h0BEE);
    repeat (5) begin
      cycle();
      chk("bp_data", 64'(out_data), 64'(held_d));
      chk("bp_ch", 64'(out_ch), 64'(held_c));
    end
    out_ready = 1;
    cycle();
    chk("refill_valid", 64'(out_valid), 64'd1);
    chk("refill_data", 64'(out_data), 64'h0BEE);

`ifdef MUX_RR_EN
    rst = 1; cycle(); rst = 0;
    mode = 1; in_valid = 16'b1000_0000_0010_0101;
    exp_seq = '{0, 2, 5, 15, 0};
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("rr_seq", 64'(out_ch), 64'(exp_seq[i]));
    end
    in_valid = '0; in_valid[14] = 1'b1;
    cycle();
    chk("rr_ptr14", 64'(out_ch), 64'd14);
    in_valid = '0; in_valid[1] = 1'b1; in_valid[15] = 1'b1;
    cycle();
    chk("rr_wrap_a", 64'(out_ch), 64'd15);
    cycle();
    chk("rr_wrap_b", 64'(out_ch), 64'd1);
    in_valid = '1;
    cycle();
    rst = 1;
    cycle();
    chk("rr_rst_valid", 64'(out_valid), 64'd0);
    rst = 0;
    cycle();
    chk("rr_after_rst", 64'(out_ch), 64'd0);
`endif

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      en        = ($urandom_range(0, 9) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      mode      = 1'($urandom);
      sel       = SW'($urandom);
      in_valid  = N'($urandom);
      for (int c = 0; c < N; c++) set_word(c, W'($urandom));
      rst       = ($urandom_range(0, 49) == 0);
      cycle();
    end
    rst = 0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
